// File: rtl/multicycle_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encoding,
// default parameter values and a helper that sizes the wait counter.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } state_e;

    localparam int PC_W_DEF    = 6;
    localparam int INSTR_W_DEF = 9;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 15;

    // Width able to hold 0..t; never narrower than one bit.
    function automatic int wait_w(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Bus between the sequencer and its surroundings: instruction memory,
// data memory, combinational decoder/ALU and register-file write controls.
//   master : the sequencer (drives requests, pc, ir, write-back controls)
//   slave  : memories + decoder (drive acks, read data, decode flags)
interface multicycle_seq_if
    import seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               is_load;
    logic               is_store;
    logic               is_halt;
    logic               reg_wen_dec;
    logic               jen;
    logic [PC_W-1:0]    jump_target;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic               rf_wen;
    logic               ld_sel;

    modport master (
        output imem_req, pc, ir, dmem_req, dmem_we, rf_wen, ld_sel,
        input  imem_ack, imem_rdata, is_load, is_store, is_halt,
               reg_wen_dec, jen, jump_target, dmem_ack
    );

    modport slave (
        input  imem_req, pc, ir, dmem_req, dmem_we, rf_wen, ld_sel,
        output imem_ack, imem_rdata, is_load, is_store, is_halt,
               reg_wen_dec, jen, jump_target, dmem_ack
    );
endinterface

// File: rtl/multicycle_seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, async active-low reset (count -> 0)
//   clr_i         : clear to 0 (wins over inc_i)
//   inc_i         : increment by one, holding at all-ones
//   cnt_o         : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer. Owns PC and instruction register and
// steps FETCH/DECODE/EXEC/(MEM)/WB with req/ack handshakes to variable
// latency instruction and data memories.
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : leave IDLE/HALT and restart at pc 0 with counters cleared
//   bus           : memory handshakes, decoder flags, pc/ir, write-back controls
//   done_o        : program halted
//   err_o         : an ack did not arrive within TIMEOUT cycles (sticky)
//   cycle_cnt_o   : active cycles, saturating
//   instr_cnt_o   : retired instructions (halt included), saturating
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    multicycle_seq_if.master    bus,
    output logic                done_o,
    output logic                err_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic [CNT_W-1:0]    instr_cnt_o
);
    localparam int            WAIT_W    = wait_w(TIMEOUT);
    localparam bit            TO_EN     = (TIMEOUT > 0);
    // Compare against TIMEOUT-1: the cycle that would become the TIMEOUT-th
    // wait cycle is the last chance for an ack.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TO_EN ? TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               load_q, load_d;
    logic               store_q, store_d;
    logic [WAIT_W-1:0]  wait_cnt;

    logic start_go, timeout_hit, active;
    logic imem_req, dmem_req, dmem_we, rf_wen, ld_sel, done, err;

    assign start_go    = start_i && ((state_q == IDLE) || (state_q == HALT));
    assign timeout_hit = TO_EN && (wait_cnt == WAIT_LAST);
    assign active      = state_q inside {FETCH, DECODE, EXEC, MEM, WB};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_i) state_d = FETCH;
            FETCH:  begin
                // ack wins over a simultaneous timeout
                if (bus.imem_ack)  state_d = DECODE;
                else if (timeout_hit) state_d = ERR;
            end
            DECODE: state_d = EXEC;
            EXEC:   begin
                if (bus.is_halt)                        state_d = HALT;
                else if (bus.is_load || bus.is_store)   state_d = MEM;
                else                                    state_d = WB;
            end
            MEM:    begin
                if (bus.dmem_ack)     state_d = WB;
                else if (timeout_hit) state_d = ERR;
            end
            WB:     state_d = FETCH;
            HALT:   if (start_i) state_d = FETCH;
            ERR:    state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Pure functions of state_q so an async reset drops requests at once.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_wen   = 1'b0;
        ld_sel   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            FETCH: imem_req = 1'b1;
            MEM:   begin
                dmem_req = 1'b1;
                dmem_we  = store_q;
            end
            WB:    begin
                rf_wen = bus.reg_wen_dec && !store_q;
                ld_sel = load_q;
            end
            HALT:  done = 1'b1;
            ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        load_d  = load_q;
        store_d = store_q;
        if (start_go) pc_d = '0;
        case (state_q)
            FETCH: if (bus.imem_ack) ir_d = bus.imem_rdata;
            // Decode flags captured once so MEM/WB do not depend on the
            // decoder staying stable.
            EXEC:  begin
                load_d  = bus.is_load;
                store_d = bus.is_store;
            end
            WB:    pc_d = bus.jen ? bus.jump_target : pc_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            ir_q    <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            load_q  <= load_d;
            store_q <= store_d;
        end
    end

    // ---------------- counters ----------------
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_go),
        .inc_i  (active),
        .cnt_o  (cycle_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (start_go),
        .inc_i  ((state_q == WB) || ((state_q == EXEC) && bus.is_halt)),
        .cnt_o  (instr_cnt_o)
    );

    // Restarts on every state change; counts cycles spent waiting for an ack.
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_d != state_q),
        .inc_i  (((state_q == FETCH) && !bus.imem_ack) ||
                 ((state_q == MEM)   && !bus.dmem_ack)),
        .cnt_o  (wait_cnt)
    );

    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.rf_wen   = rf_wen;
    assign bus.ld_sel   = ld_sel;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign done_o       = done;
    assign err_o        = err;
endmodule

// File: tb/tb_multicycle_seq.sv
module tb_multicycle_seq;
    localparam int PC_W = 6, INSTR_W = 9, CNT_W = 16, TIMEOUT = 15;
    localparam logic [8:0] I_ALU = 9'h000, I_LD = 9'h040, I_ST = 9'h080,
                           I_HLT = 9'h0C0, I_JMP = 9'h100, I_NOWR = 9'h140;

    typedef struct {
        logic [8:0] instr; int pc; int ilat; int dlat;
        int cyc; bit rf; bit ld; bit we; int dq; int pc_nx;
    } vec_t;
    typedef struct {
        int cyc; bit rf; bit ld; bit we; int dq; int pc; int icnt; int ccnt;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic done, err;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    multicycle_seq_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    multicycle_seq #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bus(bus),
        .done_o(done), .err_o(err), .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt)
    );

    always #5 clk = ~clk;

    // decoder model: op = ir[8:6]; 0 alu, 1 load, 2 store, 3 halt, 4 jump, 5 alu no write
    logic [2:0] op;
    assign op              = bus.ir[8:6];
    assign bus.is_load     = (op == 3'd1);
    assign bus.is_store    = (op == 3'd2);
    assign bus.is_halt     = (op == 3'd3);
    assign bus.jen         = (op == 3'd4);
    assign bus.jump_target = bus.ir[5:0];
    assign bus.reg_wen_dec = (op <= 3'd2);

    logic [8:0] prog [64];
    int ilat [64];
    int dlat [64];
    bit tie_ack = 1'b0;
    exp_t sb [$];
    int n_chk = 0, n_err = 0;
    int e_icnt, e_cum;
    int m_ret = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // memory responder + retirement monitor
    initial begin
        int icnt, dcnt, m_cyc, m_dq, m_prev;
        bit m_rf, m_ld, m_we;
        exp_t e;
        icnt = 0; dcnt = 0; m_cyc = 0; m_dq = 0; m_prev = 0;
        m_rf = 0; m_ld = 0; m_we = 0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.imem_rdata = prog[bus.pc];
            if (tie_ack) begin
                bus.imem_ack = 1'b1;
                bus.dmem_ack = 1'b1;
            end else begin
                if (bus.imem_req) begin
                    bus.imem_ack = (icnt == ilat[bus.pc]);
                    icnt++;
                end else begin
                    bus.imem_ack = 1'b0;
                    icnt = 0;
                end
                if (bus.dmem_req) begin
                    bus.dmem_ack = (dcnt == dlat[bus.pc]);
                    dcnt++;
                end else begin
                    bus.dmem_ack = 1'b0;
                    dcnt = 0;
                end
            end
            if (int'(instr_cnt) == m_prev + 1) begin
                m_ret++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ret_cycles", m_cyc, e.cyc);
                    chk("ret_rf_wen", int'(m_rf), int'(e.rf));
                    chk("ret_ld_sel", int'(m_ld), int'(e.ld));
                    chk("ret_dmem_we", int'(m_we), int'(e.we));
                    chk("ret_dmem_req_cycles", m_dq, e.dq);
                    chk("ret_pc", int'(bus.pc), e.pc);
                    chk("ret_instr_cnt", int'(instr_cnt), e.icnt);
                    chk("ret_cycle_cnt", int'(cycle_cnt), e.ccnt);
                end
                m_cyc = 0; m_dq = 0; m_rf = 0; m_ld = 0; m_we = 0;
            end
            m_prev = int'(instr_cnt);
            if (cycle_cnt == '0) begin
                m_cyc = 0; m_dq = 0; m_rf = 0; m_ld = 0; m_we = 0;
            end
            m_cyc++;
            if (bus.rf_wen) m_rf = 1'b1;
            if (bus.ld_sel) m_ld = 1'b1;
            if (bus.dmem_req) begin
                m_dq++;
                if (bus.dmem_we) m_we = 1'b1;
            end
        end
    end

    task automatic begin_run();
        e_icnt = 0;
        e_cum  = 0;
    endtask

    task automatic push_e(input vec_t v);
        exp_t e;
        e_icnt++;
        e_cum += v.cyc;
        e = '{v.cyc, v.rf, v.ld, v.we, v.dq, v.pc_nx, e_icnt, e_cum};
        sb.push_back(e);
    endtask

    task automatic load_v(input vec_t v);
        prog[v.pc] = v.instr;
        ilat[v.pc] = v.ilat;
        dlat[v.pc] = v.dlat;
        push_e(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tie_ack = 1'b0;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            prog[i] = I_HLT; ilat[i] = 0; dlat[i] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // returns at the negedge inside the first FETCH cycle
    task automatic do_start();
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        vec_t vt [8];
        vec_t j0, j1, j2;
        int base;
        for (int i = 0; i < 64; i++) begin
            prog[i] = I_HLT; ilat[i] = 0; dlat[i] = 0;
        end
        //        instr        pc ilat dlat cyc rf ld we dq pc_nx
        vt[0] = '{I_ALU,        0, 0,   0,   4, 1, 0, 0, 0, 1};
        vt[1] = '{I_LD,         1, 0,   3,   8, 1, 1, 0, 4, 2};
        vt[2] = '{I_ALU,        2, 2,   0,   6, 1, 0, 0, 0, 3};
        vt[3] = '{I_JMP | 9'd5, 3, 0,   0,   4, 0, 0, 0, 0, 5};
        vt[4] = '{I_ST,         5, 1,   1,   7, 0, 0, 1, 2, 6};
        vt[5] = '{I_NOWR,       6, 0,   0,   4, 0, 0, 0, 0, 7};
        vt[6] = '{I_LD,         7, 0,   0,   5, 1, 1, 0, 1, 8};
        vt[7] = '{I_HLT,        8, 0,   0,   3, 0, 0, 0, 0, 8};

        // reset state
        @(negedge clk);
        chk("rst_outputs", int'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_wen,
                                 bus.ld_sel, done, err}), 0);
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_ir", int'(bus.ir), 0);
        chk("rst_counters", int'(cycle_cnt) + int'(instr_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // acks tied high (also asserted outside their request states)
        tie_ack = 1'b1;
        prog[0] = I_ALU;
        prog[1] = I_HLT;
        begin_run();
        push_e('{I_ALU, 0, 0, 0, 4, 1, 0, 0, 0, 1});
        push_e('{I_HLT, 1, 0, 0, 3, 0, 0, 0, 0, 1});
        do_start();
        wait_drain(50);
        chk("tied_done", int'(done), 1);

        // table program with variable latencies, restarted from HALT
        tie_ack = 1'b0;
        prog[1] = I_ALU;
        begin_run();
        foreach (vt[i]) load_v(vt[i]);
        do_start();
        chk("restart_done", int'(done), 0);
        chk("restart_pc", int'(bus.pc), 0);
        chk("restart_counters", int'(cycle_cnt) + int'(instr_cnt), 0);
        wait_drain(200);
        repeat (3) @(negedge clk);
        chk("halt_done", int'(done), 1);
        chk("halt_pc", int'(bus.pc), 8);
        chk("halt_cycle_hold", int'(cycle_cnt), 41);
        chk("halt_instr_cnt", int'(instr_cnt), 8);

        // jump to 0x3F, self-jump at 0x3F, then sequential wrap to 0
        do_reset();
        j0 = '{I_JMP | 9'd63, 0,  0, 0, 4, 0, 0, 0, 0, 63};
        j1 = '{I_JMP | 9'd63, 63, 4, 0, 8, 0, 0, 0, 0, 63};
        j2 = '{I_ALU,         63, 4, 0, 8, 1, 0, 0, 0, 0};
        begin_run();
        load_v(j0);
        load_v(j1);
        push_e(j2);
        base = m_ret;
        do_start();
        for (int k = 0; k < 40 && m_ret < base + 2; k++) begin
            @(negedge clk);
            #1;
        end
        chk("wrap_second_retire", int'(m_ret >= base + 2), 1);
        prog[63] = I_ALU;
        wait_drain(40);

        // fetch timeout: no ack for 15 cycles
        do_reset();
        prog[0] = I_ALU;
        ilat[0] = 1000;
        do_start();
        repeat (14) @(negedge clk);
        chk("to_fetch_err_before", int'(err), 0);
        chk("to_fetch_req_before", int'(bus.imem_req), 1);
        @(negedge clk);
        chk("to_fetch_err", int'(err), 1);
        chk("to_fetch_req_drop", int'(bus.imem_req), 0);
        do_start();
        repeat (2) @(negedge clk);
        chk("to_err_sticky", int'({err, bus.imem_req, done}), 3'b100);

        // ack on the 15th fetch cycle wins over the timeout
        do_reset();
        ilat[0] = 14;
        prog[0] = I_ALU;
        begin_run();
        push_e('{I_ALU, 0, 14, 0, 18, 1, 0, 0, 0, 1});
        push_e('{I_HLT, 1, 0,  0, 3,  0, 0, 0, 0, 1});
        do_start();
        wait_drain(60);
        chk("ack_at_limit_no_err", int'(err), 0);

        // data timeout in MEM
        do_reset();
        prog[0] = I_LD;
        dlat[0] = 1000;
        do_start();
        repeat (17) @(negedge clk);
        chk("to_mem_req_before", int'({bus.dmem_req, err}), 2'b10);
        @(negedge clk);
        chk("to_mem_err", int'({bus.dmem_req, err}), 2'b01);

        // reset mid-MEM drops request asynchronously
        do_reset();
        prog[0] = I_LD;
        dlat[0] = 1000;
        do_start();
        repeat (3) @(negedge clk);
        chk("mid_mem_req", int'(bus.dmem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_mem_reset_outs", int'({bus.imem_req, bus.dmem_req, bus.dmem_we,
                                        bus.rf_wen, bus.ld_sel, done, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset mid-FETCH
        ilat[0] = 1000;
        do_start();
        repeat (3) @(negedge clk);
        chk("mid_fetch_req", int'(bus.imem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_fetch_reset_req", int'(bus.imem_req), 0);
        chk("mid_fetch_reset_cnt", int'(cycle_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Parametrised multi-cycle sequencer that succeeds the single-cycle processor top's implicit control.
- Owns the PC, the instruction register and per-phase enables.
- Sequences FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction and data memory, so both may have variable latency.
- Sits between the program-memory and data-memory ports and the existing combinational decoder, ALU and register file. Adds halt/restart, wait-timeout error and performance counters.

Parameters:
PC_W, 6, program counter width; PC wraps modulo 2^PC_W
INSTR_W, 9, machine-code width
CNT_W, 16, width of cycle and retired-instruction counters
TIMEOUT, 15, max wait cycles for any ack before ERR; 0 disables the timeout

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  leaves IDLE/HALT, restarts at PC=0
imem_req  out  1  fetch request, held until ack
imem_ack  in  1  instruction valid this cycle
imem_rdata  in  INSTR_W  instruction word
pc  out  PC_W  current PC, drives instruction address
ir  out  INSTR_W  latched instruction, feeds decoder
is_load  in  1  decoder: load
is_store  in  1  decoder: store
is_halt  in  1  decoder: halt
reg_wen_dec  in  1  decoder: instruction writes a register
jen  in  1  decoder/ALU: take jump
jump_target  in  PC_W  jump destination from the jump LUT
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  store strobe, valid with dmem_req
dmem_ack  in  1  data access complete; load data valid
rf_wen  out  1  register write enable, one-cycle pulse
ld_sel  out  1  1 = write-back from data memory, 0 = from ALU
Done  out  1  program halted
err  out  1  ack timeout; sticky
cycle_cnt  out  CNT_W  active cycles, saturating
instr_cnt  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; pc=0; ir=0; counters=0.
  - All outputs 0: imem_req, dmem_req, dmem_we, rf_wen, ld_sel, Done, err.
- IDLE: Start=1 -> FETCH, pc=0, counters cleared.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir<=imem_rdata -> DECODE.
  - Otherwise wait_cnt++.
- DECODE: one cycle; decoder settles from ir.
- EXEC:
  - is_halt -> HALT; pc not advanced; instr_cnt++.
  - is_load or is_store -> MEM. The flags are registered here and held through WB.
  - Otherwise -> WB.
- MEM:
  - dmem_req=1; dmem_we=registered is_store.
  - On dmem_ack -> WB; dmem_req drops next cycle.
- WB:
  - rf_wen = reg_wen_dec AND NOT store.
  - ld_sel = registered is_load.
  - pc <= jen ? jump_target : pc+1, wrapping at PC_W bits.
  - instr_cnt++; -> FETCH.
- HALT:
  - Done=1 until Start=1.
  - Start=1 -> FETCH with pc=0, counters cleared, Done drops.
- ERR:
  - Entered when wait_cnt reaches TIMEOUT in FETCH or MEM (TIMEOUT>0).
  - err=1, all requests 0; only reset exits.
- wait_cnt clears on every state entry. An ack arriving in the same cycle the count hits TIMEOUT wins: no ERR.
- Latency with zero-wait memories (ack in the request's cycle):
  - non-memory instruction: 4 cycles;
  - load/store: 5 cycles;
  - each wait cycle adds 1.
- cycle_cnt increments in FETCH, DECODE, EXEC, MEM and WB. instr_cnt increments on WB and on halt. Both hold at all-ones.
- Acks outside the matching request state are ignored.
- Start is ignored in FETCH, DECODE, EXEC, MEM, WB and ERR.
- Reset mid-MEM or mid-FETCH aborts immediately: requests drop asynchronously, no rf_wen.

Decomposition:
- Shared package `seq_pkg`: state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR) and the default parameter constants.
- One natural sub-module: `sat_counter` (parametrised width, clear, inc, saturation), instantiated for cycle_cnt, instr_cnt and wait_cnt.

Test Plan:
- Reset then Start pulse; ALU instruction; imem_ack and dmem_ack tied 1, reg_wen_dec=1, jen=0 -> rf_wen pulses on cycle 4 after Start; pc 0->1; instr_cnt=1; cycle_cnt=4.
- Load with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0; then rf_wen=1 with ld_sel=1; 8 cycles total.
- Store at pc=5 -> dmem_we=1 during MEM; rf_wen stays 0 in WB; pc=6.
- jen=1, jump_target=0x3F at pc=0x3F; then a non-jump instruction at 0x3F -> pc=0x3F, then wraps to 0x00.
- is_halt at pc=2 -> Done=1, pc stays 2, instr_cnt counts the halt; Start -> Done=0, pc=0, counters cleared.
- TIMEOUT=15, imem_ack held 0 -> err=1 and imem_req=0 after 15 wait cycles. Separate case: ack on exactly the 15th wait cycle -> no error. Reset asserted mid-wait -> all outputs 0 immediately.
